// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-requester flash arbiter.
package flash_arb_pkg;

  // Arbiter FSM encoding; IDLE is zero so a reset state reads as 0 on the debug port.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    ERR_RSP  = 2'd2
  } state_e;

  // Response error codes returned on rk_rerror_o.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_WP      = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way round-robin picker: a one-bit pointer naming the preferred
// requester plus a combinational winner. The pointer moves to the loser
// on every accepted grant.
module flash_arb_rr (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       win_o,
  output logic       ptr_o
);

  logic ptr_q;

  // Winner: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    win_o = 1'b0;
    case (req_i)
      2'b01:   win_o = 1'b0;
      2'b10:   win_o = 1'b1;
      2'b11:   win_o = ptr_q;
      default: win_o = 1'b0;
    endcase
  end

  // Pointer hands preference to the requester that did not just win.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (advance_i) begin
      ptr_q <= ~win_o;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/flash_arb.sv
// Flash arbiter: two requesters share one flash port with a single
// outstanding transaction. Writes into the protected window are refused
// without touching the flash; missing responses time out.
//
// Handshake: rk_gnt_o is combinational and only asserted in IDLE; a request
// is accepted in the cycle rk_req_i && rk_gnt_o are both high, and the
// requester's command inputs are sampled in that same cycle. The response
// is a single-cycle rk_rvalid_o strobe with rk_rdata_o/rk_rerror_o valid
// alongside it; there is no back-pressure on responses.
module flash_arb
  import flash_arb_pkg::*;
#(
  parameter int Aw            = 13,
  parameter int Dw            = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // requester 0
  input  logic          r0_req_i,
  output logic          r0_gnt_o,
  input  logic          r0_we_i,
  input  logic [Aw-1:0] r0_addr_i,
  input  logic [Dw-1:0] r0_wdata_i,
  input  logic [Dw-1:0] r0_wmask_i,
  output logic [Dw-1:0] r0_rdata_o,
  output logic          r0_rvalid_o,
  output logic [1:0]    r0_rerror_o,
  // requester 1
  input  logic          r1_req_i,
  output logic          r1_gnt_o,
  input  logic          r1_we_i,
  input  logic [Aw-1:0] r1_addr_i,
  input  logic [Dw-1:0] r1_wdata_i,
  input  logic [Dw-1:0] r1_wmask_i,
  output logic [Dw-1:0] r1_rdata_o,
  output logic          r1_rvalid_o,
  output logic [1:0]    r1_rerror_o,
  // flash side
  output logic          f_cs_o,
  output logic          f_we_o,
  output logic [Aw-1:0] f_addr_o,
  output logic [Dw-1:0] f_wdata_o,
  output logic [Dw-1:0] f_wmask_o,
  input  logic [Dw-1:0] f_rdata_i,
  input  logic          f_dvalid_i,
  // write protection window (inclusive)
  input  logic          wp_en_i,
  input  logic [Aw-1:0] wp_lo_i,
  input  logic [Aw-1:0] wp_hi_i,
  // debug: current FSM state
  output logic [1:0]    state_o
);

  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);

  state_e          state_q;
  logic            owner_q;
  logic [CntW-1:0] cnt_q;

  logic            win;
  logic            ptr_unused;
  logic            grant;
  logic            sel_we;
  logic [Aw-1:0]   sel_addr;
  logic [Dw-1:0]   sel_wdata;
  logic [Dw-1:0]   sel_wmask;
  logic            wp_hit;
  logic            timeout;
  logic            rsp_valid;
  logic [1:0]      rsp_err;
  logic [Dw-1:0]   rsp_data;

  flash_arb_rr u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     ({r1_req_i, r0_req_i}),
    .advance_i (grant),
    .win_o     (win),
    .ptr_o     (ptr_unused)
  );

  // Grants exist only in IDLE and are forced low while reset is held.
  assign grant    = rst_ni && (state_q == IDLE) && (r0_req_i || r1_req_i);
  assign r0_gnt_o = grant && !win;
  assign r1_gnt_o = grant &&  win;

  // Command of the current winner.
  always_comb begin
    sel_we    = win ? r1_we_i    : r0_we_i;
    sel_addr  = win ? r1_addr_i  : r0_addr_i;
    sel_wdata = win ? r1_wdata_i : r0_wdata_i;
    sel_wmask = win ? r1_wmask_i : r0_wmask_i;
  end

  // Protection covers writes only; reads inside the window pass through.
  assign wp_hit = wp_en_i && sel_we && (wp_lo_i <= sel_addr) && (sel_addr <= wp_hi_i);

  // Flash command is presented only in the accepting cycle, zero otherwise.
  always_comb begin
    f_cs_o    = grant && !wp_hit;
    f_we_o    = f_cs_o ? sel_we    : 1'b0;
    f_addr_o  = f_cs_o ? sel_addr  : '0;
    f_wdata_o = f_cs_o ? sel_wdata : '0;
    f_wmask_o = f_cs_o ? sel_wmask : '0;
  end

  assign timeout = (cnt_q == CntMax);

  // Response generation; dvalid is only looked at while waiting.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = ERR_NONE;
    rsp_data  = '0;
    case (state_q)
      WAIT_RSP: begin
        if (f_dvalid_i) begin
          rsp_valid = 1'b1;
          rsp_data  = f_rdata_i;
        end else if (timeout) begin
          rsp_valid = 1'b1;
          rsp_err   = ERR_TIMEOUT;
        end
      end
      ERR_RSP: begin
        rsp_valid = 1'b1;
        rsp_err   = ERR_WP;
      end
      default: ;
    endcase
  end

  // Route the response to the owner only; the other requester sees zeros.
  always_comb begin
    r0_rvalid_o = rsp_valid && !owner_q;
    r1_rvalid_o = rsp_valid &&  owner_q;
    r0_rerror_o = r0_rvalid_o ? rsp_err  : 2'b00;
    r1_rerror_o = r1_rvalid_o ? rsp_err  : 2'b00;
    r0_rdata_o  = r0_rvalid_o ? rsp_data : '0;
    r1_rdata_o  = r1_rvalid_o ? rsp_data : '0;
  end

  // Transaction FSM: owner and wait counter are captured on grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            owner_q <= win;
            cnt_q   <= '0;
            state_q <= wp_hit ? ERR_RSP : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (f_dvalid_i || timeout) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ERR_RSP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_flash_arb.sv
// Directed bench for flash_arb: reset, alternation, write protection,
// timeout, mid-transaction reset and protected reads.
module tb_flash_arb;

  logic        clk;
  logic        rst_ni;
  logic        r0_req, r0_gnt, r0_we, r0_rvalid;
  logic [12:0] r0_addr;
  logic [31:0] r0_wdata, r0_wmask, r0_rdata;
  logic [1:0]  r0_rerror;
  logic        r1_req, r1_gnt, r1_we, r1_rvalid;
  logic [12:0] r1_addr;
  logic [31:0] r1_wdata, r1_wmask, r1_rdata;
  logic [1:0]  r1_rerror;
  logic        f_cs, f_we, f_dvalid;
  logic [12:0] f_addr;
  logic [31:0] f_wdata, f_wmask, f_rdata;
  logic        wp_en;
  logic [12:0] wp_lo, wp_hi;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  flash_arb dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .r0_req_i(r0_req), .r0_gnt_o(r0_gnt), .r0_we_i(r0_we), .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata), .r0_wmask_i(r0_wmask), .r0_rdata_o(r0_rdata),
    .r0_rvalid_o(r0_rvalid), .r0_rerror_o(r0_rerror),
    .r1_req_i(r1_req), .r1_gnt_o(r1_gnt), .r1_we_i(r1_we), .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata), .r1_wmask_i(r1_wmask), .r1_rdata_o(r1_rdata),
    .r1_rvalid_o(r1_rvalid), .r1_rerror_o(r1_rerror),
    .f_cs_o(f_cs), .f_we_o(f_we), .f_addr_o(f_addr), .f_wdata_o(f_wdata),
    .f_wmask_o(f_wmask), .f_rdata_i(f_rdata), .f_dvalid_i(f_dvalid),
    .wp_en_i(wp_en), .wp_lo_i(wp_lo), .wp_hi_i(wp_hi),
    .state_o(state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_r0_gnt"},    r0_gnt,    0);
    check({tag, "_r1_gnt"},    r1_gnt,    0);
    check({tag, "_r0_rvalid"}, r0_rvalid, 0);
    check({tag, "_r1_rvalid"}, r1_rvalid, 0);
    check({tag, "_r0_rdata"},  r0_rdata,  0);
    check({tag, "_r1_rdata"},  r1_rdata,  0);
    check({tag, "_r0_rerror"}, r0_rerror, 0);
    check({tag, "_r1_rerror"}, r1_rerror, 0);
    check({tag, "_f_cs"},      f_cs,      0);
    check({tag, "_f_addr"},    f_addr,    0);
    check({tag, "_state"},     state,     0);
  endtask

  logic [12:0] wr_addr [3];
  logic        wr_prot [3];
  logic [31:0] exp_rd;

  initial begin
    rst_ni = 1'b0; f_dvalid = 1'b0; f_rdata = '0;
    wp_en = 1'b0; wp_lo = '0; wp_hi = '0;
    r0_we = 1'b0; r0_addr = 13'h004; r0_wdata = '0; r0_wmask = '0;
    r1_we = 1'b0; r1_addr = 13'h008; r1_wdata = '0; r1_wmask = '0;
    // Both requesters hold req from reset onwards.
    r0_req = 1'b1; r1_req = 1'b1;

    // Reset state: requests must not leak through while reset is held.
    #2;
    check_quiet("reset");
    step(); step();
    rst_ni = 1'b1;

    // Alternation under continuous contention, one-cycle flash latency.
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    for (int g = 0; g < 4; g++) begin
      logic [0:0] e;
      e = exp_q.pop_front();
      #1;
      check("alt_gnt_count", 32'(r0_gnt) + 32'(r1_gnt), 1);
      check("alt_gnt_id", r1_gnt, e);
      check("alt_cs", f_cs, 1);
      check("alt_addr", f_addr, e ? 13'h008 : 13'h004);
      step();
      f_dvalid = 1'b1; f_rdata = 32'h1000 + g;
      #1;
      check("alt_rsp_gnt_low", 32'(r0_gnt) + 32'(r1_gnt), 0);
      check("alt_r0_rvalid", r0_rvalid, !e);
      check("alt_r1_rvalid", r1_rvalid, e);
      check("alt_rdata", e ? r1_rdata : r0_rdata, 32'h1000 + g);
      check("alt_other_rdata", e ? r0_rdata : r1_rdata, 0);
      step();
      f_dvalid = 1'b0;
    end
    r0_req = 1'b0; r1_req = 1'b0;

    // Lone r0 read, flash answers one cycle later.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 13'h010;
    #1;
    check("rd_r0_gnt", r0_gnt, 1);
    check("rd_r1_gnt", r1_gnt, 0);
    check("rd_cs", f_cs, 1);
    check("rd_we", f_we, 0);
    check("rd_addr", f_addr, 13'h010);
    step();
    r0_req = 1'b0; f_dvalid = 1'b1; f_rdata = 32'hDEADBEEF;
    #1;
    check("rd_r0_rvalid", r0_rvalid, 1);
    check("rd_r0_rdata", r0_rdata, 32'hDEADBEEF);
    check("rd_r0_rerror", r0_rerror, 2'b00);
    check("rd_r1_rvalid", r1_rvalid, 0);
    check("rd_r1_rdata", r1_rdata, 0);
    step();
    f_dvalid = 1'b0;
    #1;
    check("rd_after_r0_rvalid", r0_rvalid, 0);

    // Write protection window boundaries from r1.
    wp_en = 1'b1; wp_lo = 13'h100; wp_hi = 13'h1FF;
    wr_addr[0] = 13'h100; wr_prot[0] = 1'b1;
    wr_addr[1] = 13'h1FF; wr_prot[1] = 1'b1;
    wr_addr[2] = 13'h200; wr_prot[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      r1_req = 1'b1; r1_we = 1'b1; r1_addr = wr_addr[i];
      r1_wdata = 32'hA5A50000 | i; r1_wmask = 32'hFFFF0000;
      #1;
      check("wp_gnt", r1_gnt, 1);
      check("wp_cs", f_cs, !wr_prot[i]);
      check("wp_f_we", f_we, !wr_prot[i]);
      check("wp_f_addr", f_addr, wr_prot[i] ? 13'h000 : wr_addr[i]);
      check("wp_f_wdata", f_wdata, wr_prot[i] ? 32'h0 : (32'hA5A50000 | i));
      check("wp_f_wmask", f_wmask, wr_prot[i] ? 32'h0 : 32'hFFFF0000);
      step();
      r1_req = 1'b0;
      f_dvalid = !wr_prot[i]; f_rdata = 32'h00000077;
      #1;
      check("wp_r1_rvalid", r1_rvalid, 1);
      check("wp_r1_rerror", r1_rerror, wr_prot[i] ? 2'b01 : 2'b00);
      check("wp_r1_rdata", r1_rdata, wr_prot[i] ? 32'h0 : 32'h77);
      check("wp_r0_rvalid", r0_rvalid, 0);
      check("wp_rsp_cs", f_cs, 0);
      step();
      f_dvalid = 1'b0;
    end

    // Read inside the protected window is a normal access.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 13'h150;
    #1;
    check("prd_gnt", r0_gnt, 1);
    check("prd_cs", f_cs, 1);
    step();
    r0_req = 1'b0; f_dvalid = 1'b1; f_rdata = 32'h12345678;
    #1;
    check("prd_rvalid", r0_rvalid, 1);
    check("prd_rerror", r0_rerror, 2'b00);
    check("prd_rdata", r0_rdata, 32'h12345678);
    step();
    f_dvalid = 1'b0; wp_en = 1'b0;

    // Timeout: grant at cycle 0, error strobe at cycle 16, late dvalid ignored.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 13'h020;
    #1;
    check("to_gnt", r0_gnt, 1);
    step();
    r0_req = 1'b0;
    for (int c = 1; c < 16; c++) begin
      #1;
      check("to_wait_rvalid", r0_rvalid, 0);
      step();
    end
    #1;
    check("to_rvalid", r0_rvalid, 1);
    check("to_rerror", r0_rerror, 2'b10);
    check("to_rdata", r0_rdata, 0);
    check("to_r1_rvalid", r1_rvalid, 0);
    step();
    #1;
    check("to_c17_rvalid", r0_rvalid, 0);
    check("to_c17_state", state, 0);
    step();
    f_dvalid = 1'b1; f_rdata = 32'h0BADF00D;
    #1;
    check("late_r0_rvalid", r0_rvalid, 0);
    check("late_r1_rvalid", r1_rvalid, 0);
    check("late_r0_rdata", r0_rdata, 0);
    step();
    f_dvalid = 1'b0;

    // Reset mid-transaction: r0 granted (pointer moves to 1), then reset in WAIT_RSP.
    r0_req = 1'b1; r0_addr = 13'h033;
    #1;
    check("rst_pre_gnt", r0_gnt, 1);
    step();
    r0_req = 1'b0;
    #1;
    check("rst_pre_state", state, 1);
    rst_ni = 1'b0; f_dvalid = 1'b1; f_rdata = 32'h55AA55AA;
    #1;
    check_quiet("rst_mid");
    step();
    rst_ni = 1'b1;
    #1;
    check("rst_post_r0_rvalid", r0_rvalid, 0);
    check("rst_post_r1_rvalid", r1_rvalid, 0);
    check("rst_post_state", state, 0);
    step();
    f_dvalid = 1'b0;
    // Pointer must be back at requester 0 after reset.
    r0_req = 1'b1; r1_req = 1'b1;
    #1;
    check("rst_ptr_r0_gnt", r0_gnt, 1);
    check("rst_ptr_r1_gnt", r1_gnt, 0);
    step();
    r0_req = 1'b0; r1_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_arb.md
FLASH_ARB -- requirements
Module: flash_arb

Interface
REQ-001 SHALL have parameters: Aw, default 13, flash word-address width; Dw, default 32, data width; TimeoutCycles, default 16, maximum response wait in cycles.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have, for each requester k in {0,1}, port rk_req_i  input  1  request valid.
REQ-005 SHALL have, for each requester k, port rk_gnt_o  output  1  request accepted this cycle.
REQ-006 SHALL have, for each requester k, port rk_we_i  input  1  write (1) or read (0).
REQ-007 SHALL have, for each requester k, port rk_addr_i  input  Aw  word address.
REQ-008 SHALL have, for each requester k, ports rk_wdata_i and rk_wmask_i  input  Dw each  write data and bit mask.
REQ-009 SHALL have, for each requester k, port rk_rdata_o  output  Dw  response data.
REQ-010 SHALL have, for each requester k, port rk_rvalid_o  output  1  response strobe, one cycle.
REQ-011 SHALL have, for each requester k, port rk_rerror_o  output  2  response error code.
REQ-012 SHALL have flash-side ports f_cs_o (output, 1), f_we_o (output, 1), f_addr_o (output, Aw), f_wdata_o (output, Dw) and f_wmask_o (output, Dw).
REQ-013 SHALL have flash-side ports f_rdata_i (input, Dw) and f_dvalid_i (input, 1).
REQ-014 SHALL have write-protect ports wp_en_i (input, 1), wp_lo_i (input, Aw) and wp_hi_i (input, Aw); together they define an inclusive protected address window.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT_RSP and ERR_RSP, and SHALL allow exactly one outstanding transaction in total.
REQ-016 In IDLE with exactly one requester asserting req, SHALL assert that requester's gnt combinationally in the same cycle.
REQ-017 In IDLE with both requesters asserting req, SHALL grant the requester named by the round-robin pointer.
REQ-018 In any state other than IDLE, all gnt outputs SHALL be 0.
REQ-019 On every grant, the round-robin pointer SHALL move to the non-granted requester.
REQ-020 On a grant, SHALL latch the owner and SHALL drive f_cs_o=1 for exactly that cycle, with f_we_o/f_addr_o/f_wdata_o/f_wmask_o equal to the winner's inputs; the FSM then goes to WAIT_RSP.
REQ-021 A granted write with wp_en_i=1 and wp_lo_i <= addr <= wp_hi_i (unsigned compare) SHALL keep f_cs_o=0 and SHALL enter ERR_RSP.
REQ-022 In ERR_RSP, SHALL pulse owner rvalid=1 with rerror=2'b01 and rdata=0 for one cycle, then return to IDLE.
REQ-023 In WAIT_RSP, on f_dvalid_i=1, SHALL pulse owner rvalid=1, rerror=2'b00 and rdata=f_rdata_i in the same cycle, then return to IDLE.
REQ-024 In WAIT_RSP, a counter SHALL start at 0 on entry and increment every cycle without dvalid.
REQ-025 When the WAIT_RSP counter reaches TimeoutCycles-1 without dvalid, SHALL pulse owner rvalid with rerror=2'b10 and rdata=0, then return to IDLE.
REQ-026 SHALL ignore f_dvalid_i in IDLE and ERR_RSP; a late dvalid arriving after a timeout SHALL NOT be routed to any requester.
REQ-027 SHALL NOT issue a new grant in the cycle a response is delivered; with a one-cycle flash latency the minimum spacing between grants is 2 cycles.
REQ-028 The non-owner's rvalid SHALL always be 0, and its rdata SHALL be 0.

Reset
REQ-029 While rst_ni=0, SHALL hold state=IDLE, pointer=0 (requester 0 preferred), counter=0, and all outputs (gnt, rvalid, rerror, rdata, f_*) at 0.
REQ-030 A reset asserted mid-transaction SHALL abandon the transaction, and SHALL ignore any dvalid arriving after reset release.

Structure
REQ-031 Package flash_arb_pkg SHALL hold the state enum and the error-code constants ERR_NONE=2'b00, ERR_WP=2'b01 and ERR_TIMEOUT=2'b10.
REQ-032 The two-way round-robin picker (pointer plus combinational winner) SHALL be a sub-module named flash_arb_rr.

Verification
REQ-033 Stimulus: r0 read addr 0x010 alone, flash returns 0xDEADBEEF one cycle later. Required response: r0_gnt in cycle 0, r0_rvalid with 0xDEADBEEF in cycle 1, r1_rvalid=0 throughout.
REQ-034 Stimulus: both requesters hold req continuously from reset. Required response: grants alternate r0, r1, r0, r1 at a 2-cycle spacing.
REQ-035 Stimulus: wp_en_i=1, lo=0x100, hi=0x1FF; r1 writes to addr 0x100, then 0x1FF, then 0x200. Required response: the first two produce f_cs_o=0 and rerror=01; the third produces f_cs_o=1 and rerror=00.
REQ-036 Stimulus: a read is granted and dvalid is never returned. Required response: rvalid with rerror=10 in cycle 16 after the grant; a dvalid injected at cycle 18 produces no rvalid.
REQ-037 Stimulus: rst_ni is pulled low during WAIT_RSP, then flash dvalid arrives after release. Required response: all outputs read 0 and no rvalid is produced.
REQ-038 Stimulus: an r0 read to a protected address with wp_en_i=1. Required response: normal flash access with rerror=00, since protection applies to writes only.
